// File: rtl/debounce_pkg.sv
// Shared types and helpers for the input debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_CHK_HI = 2'd1,
    ST_HIGH   = 2'd2,
    ST_CHK_LO = 2'd3
  } db_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Keeps running regardless of any enable in the surrounding logic.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  // Shift the raw bit through the flop chain; clear drops all stages to 0.
  always_ff @(posedge clk) begin
    if (clr) sync <= '0;
    else     sync <= {sync[STAGES-2:0], d};
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Input debouncer: synchronize raw_in, sample it on a prescaled tick and
// only change level_out after STABLE_CNT consecutive equal samples.
// Optional feature macro DEBOUNCE_EDGE_PULSE_EN: when defined, rise_pulse and
// fall_pulse strobe one cycle after level_out changes; otherwise both are 0.
//
//  state     | meaning
//  ST_LOW    | level_out=0, input stable low
//  ST_CHK_HI | level_out=0, counting consecutive high samples
//  ST_HIGH   | level_out=1, input stable high
//  ST_CHK_LO | level_out=1, counting consecutive low samples
module input_debounce
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE    = 1000,
  parameter int STABLE_CNT  = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic raw_in,
  input  logic en,
  output logic level_out,
  output logic sample_tick,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int PW = cnt_w(PRESCALE);
  localparam int SW = cnt_w(STABLE_CNT);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] S_LAST = SW'(STABLE_CNT - 1);

  logic          s;
  logic [PW-1:0] pcnt;
  logic [SW-1:0] scnt;
  db_state_t     state;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .clr (clr),
    .d   (raw_in),
    .q   (s)
  );

  assign sample_tick = en && (pcnt == P_LAST);

  // Prescaler: free-running modulo counter, frozen (not cleared) while en=0.
  always_ff @(posedge clk) begin
    if (clr)     pcnt <= '0;
    else if (en) pcnt <= (pcnt == P_LAST) ? '0 : pcnt + PW'(1);
  end

  // Debounce FSM: advances only on sample ticks; level_out tracks ST_HIGH/ST_CHK_LO.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_LOW;
      scnt      <= '0;
      level_out <= 1'b0;
    end else if (sample_tick) begin
      case (state)
        ST_LOW: begin
          if (s) begin
            state <= ST_CHK_HI;
            scnt  <= SW'(1);
          end
        end
        ST_CHK_HI: begin
          if (!s) begin
            state <= ST_LOW;
            scnt  <= '0;
          end else if (scnt == S_LAST) begin
            state     <= ST_HIGH;
            level_out <= 1'b1;
            scnt      <= '0;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        ST_HIGH: begin
          if (!s) begin
            state <= ST_CHK_LO;
            scnt  <= SW'(1);
          end
        end
        ST_CHK_LO: begin
          if (s) begin
            state <= ST_HIGH;
            scnt  <= '0;
          end else if (scnt == S_LAST) begin
            state     <= ST_LOW;
            level_out <= 1'b0;
            scnt      <= '0;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        default: begin
          state     <= ST_LOW;
          scnt      <= '0;
          level_out <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic level_d;

  // Edge strobes: compare level_out with its one-cycle-delayed copy.
  always_ff @(posedge clk) begin
    if (clr) begin
      level_d    <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      level_d    <= level_out;
      rise_pulse <= level_out & ~level_d;
      fall_pulse <= ~level_out & level_d;
    end
  end
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif

endmodule
